// File: rtl/hier_seq_pkg.sv
// Shared state type and constants for the hierarchy sequencing node.
package hier_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } hier_seq_state_e;

  localparam int unsigned WDOG_CNT_RST = 0;

endpackage

// File: rtl/hier_seq_wdog.sv
// Per-child watchdog: clear/enable cycle counter with a limit-reached flag.
module hier_seq_wdog
  import hier_seq_pkg::*;
#(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic lim_o
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Flag fires in the cycle whose count would bring the total to MAX.
  assign lim_o = en_i && (cnt_q == CW'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CW'(WDOG_CNT_RST);
    end else if (en_i && !lim_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(WDOG_CNT_RST);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hier_seq_node.sv
// Sequences NUM_CHILD children one at a time through a start/done handshake.
// Optional per-child watchdog is compiled in with HIER_SEQ_NODE_WDOG_EN.
module hier_seq_node
  import hier_seq_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
  parameter int WDOG_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [IDX_W-1:0]     cur_idx_o,
  output logic [IDX_W-1:0]     err_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  hier_seq_state_e      state_q, state_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]     err_idx_q, err_idx_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_CHILD-1:0] child_start_q, child_start_d;
  logic [NUM_CHILD-1:0] idx_hot_d;
  logic [NUM_CHILD-1:0] done_hit;
  logic                 sel_done;
  logic                 wdog_lim;

  // Only the selected child's done bit may advance the sequence.
  generate
    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_child
      assign idx_hot_d[gi] = (cur_idx_d == IDX_W'(gi));
      assign done_hit[gi]  = child_done_i[gi] && (cur_idx_q == IDX_W'(gi));
    end
  endgenerate

  assign sel_done = |done_hit;

`ifdef HIER_SEQ_NODE_WDOG_EN
  hier_seq_wdog #(
    .MAX(WDOG_MAX)
  ) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(state_q == LAUNCH),
    .en_i (state_q == WAIT),
    .lim_o(wdog_lim)
  );
`else
  assign wdog_lim = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = LAUNCH;
          cur_idx_d = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (sel_done) begin
          if (cur_idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            cur_idx_d = cur_idx_q + 1'b1;
            state_d   = LAUNCH;
          end
        end else if (wdog_lim) begin
          err_d     = 1'b1;
          err_idx_d = cur_idx_q;
          state_d   = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats start, done and timeout; bookkeeping is frozen as it was.
    if (abort_i) begin
      state_d   = IDLE;
      cur_idx_d = cur_idx_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned.
  assign child_start_d = (state_d == LAUNCH) ? idx_hot_d : '0;
  assign busy_d        = (state_d != IDLE);
  assign done_d        = (state_d == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_idx_q     <= '0;
      err_idx_q     <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      child_start_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_idx_q     <= cur_idx_d;
      err_idx_q     <= err_idx_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      child_start_q <= child_start_d;
    end
  end

  assign child_start_o = child_start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cur_idx_o     = cur_idx_q;
  assign err_idx_o     = err_idx_q;

endmodule
